// File: rtl/branch_flush_ctrl.sv
// branch_flush_ctrl: commits the head branch and, on a mispredict, sequences
// flush -> discard report -> fetch redirect before issue resumes.
`default_nettype none

module branch_flush_ctrl #(
  parameter int ADDR_WIDTH        = 14,
  parameter int COMMIT_RING_WIDTH = 4,
  parameter int FLUSH_CYCLES      = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         b_valid,
  output logic                         b_ready,
  input  logic                         b_resolved,
  input  logic                         b_taken,
  input  logic                         b_pred,
  input  logic [ADDR_WIDTH-1:0]        b_target,
  input  logic [ADDR_WIDTH-1:0]        b_fallthrough,
  input  logic [COMMIT_RING_WIDTH-1:0] in_count,
  output logic                         flush,
  output logic                         issue_stall,
  output logic                         discard_valid,
  output logic [COMMIT_RING_WIDTH-1:0] discard_in,
  output logic                         redirect_valid,
  input  logic                         redirect_ready,
  output logic [ADDR_WIDTH-1:0]        redirect_pc,
  output logic [31:0]                  mispredict_cnt
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  localparam int CW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CW-1:0] FLUSH_LOAD = CW'(FLUSH_CYCLES - 1);

  state_t                       state, state_next;
  logic [CW-1:0]                flush_cnt;
  logic [ADDR_WIDTH-1:0]        pc_q;
  logic [COMMIT_RING_WIDTH-1:0] discard_q;
  logic                         discard_pulse_q;
  logic [31:0]                  cnt_q;
  logic                         mispredict;

  always_comb begin
    state_next = state;
    b_ready    = 1'b0;
    mispredict = 1'b0;
    case (state)
      IDLE: begin
        b_ready = b_valid && b_resolved && !reset;
        if (b_ready && (b_taken != b_pred)) begin
          mispredict = 1'b1;
          state_next = FLUSH;
        end
      end
      FLUSH: begin
        if (flush_cnt == '0) state_next = REDIRECT;
      end
      REDIRECT: begin
        if (redirect_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      flush_cnt       <= '0;
      pc_q            <= '0;
      discard_q       <= '0;
      discard_pulse_q <= 1'b0;
      cnt_q           <= '0;
    end else begin
      state           <= state_next;
      discard_pulse_q <= mispredict;
      if (mispredict) begin
        pc_q      <= b_taken ? b_target : b_fallthrough;
        discard_q <= in_count;
        flush_cnt <= FLUSH_LOAD;
        if (cnt_q != 32'hFFFF_FFFF) cnt_q <= cnt_q + 32'd1;
      end else if (state == FLUSH && flush_cnt != '0) begin
        flush_cnt <= flush_cnt - 1'b1;
      end
    end
  end

  // All front-end controls are decoded from registered state only.
  assign flush          = (state == FLUSH);
  assign issue_stall    = (state != IDLE);
  assign redirect_valid = (state == REDIRECT);
  assign redirect_pc    = pc_q;
  assign discard_valid  = discard_pulse_q;
  assign discard_in     = discard_q;
  assign mispredict_cnt = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_branch_flush_ctrl.sv
// Directed bench for branch_flush_ctrl: FLUSH_CYCLES=2 instance for most
// scenarios, FLUSH_CYCLES=1 instance for back-to-back mispredicts.
`default_nettype none

module tb_branch_flush_ctrl;
  localparam int AW = 14;
  localparam int CRW = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // instance A (FLUSH_CYCLES = 2)
  logic           b_valid, b_ready, b_resolved, b_taken, b_pred;
  logic [AW-1:0]  b_target, b_fallthrough, redirect_pc;
  logic [CRW-1:0] in_count, discard_in;
  logic           flush, issue_stall, discard_valid, redirect_valid, redirect_ready;
  logic [31:0]    mispredict_cnt;

  // instance B (FLUSH_CYCLES = 1)
  logic           b_valid1, b_ready1, b_resolved1, b_taken1, b_pred1;
  logic [AW-1:0]  b_target1, b_fallthrough1, redirect_pc1;
  logic [CRW-1:0] in_count1, discard_in1;
  logic           flush1, issue_stall1, discard_valid1, redirect_valid1, redirect_ready1;
  logic [31:0]    mispredict_cnt1;

  branch_flush_ctrl #(.ADDR_WIDTH(AW), .COMMIT_RING_WIDTH(CRW), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .reset(reset),
    .b_valid(b_valid), .b_ready(b_ready), .b_resolved(b_resolved),
    .b_taken(b_taken), .b_pred(b_pred), .b_target(b_target),
    .b_fallthrough(b_fallthrough), .in_count(in_count),
    .flush(flush), .issue_stall(issue_stall),
    .discard_valid(discard_valid), .discard_in(discard_in),
    .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
    .redirect_pc(redirect_pc), .mispredict_cnt(mispredict_cnt)
  );

  branch_flush_ctrl #(.ADDR_WIDTH(AW), .COMMIT_RING_WIDTH(CRW), .FLUSH_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset),
    .b_valid(b_valid1), .b_ready(b_ready1), .b_resolved(b_resolved1),
    .b_taken(b_taken1), .b_pred(b_pred1), .b_target(b_target1),
    .b_fallthrough(b_fallthrough1), .in_count(in_count1),
    .flush(flush1), .issue_stall(issue_stall1),
    .discard_valid(discard_valid1), .discard_in(discard_in1),
    .redirect_valid(redirect_valid1), .redirect_ready(redirect_ready1),
    .redirect_pc(redirect_pc1), .mispredict_cnt(mispredict_cnt1)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance one clock; sample 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    b_valid = 0; b_resolved = 0; b_taken = 0; b_pred = 0;
  endtask

  task automatic drive_branch(input logic taken, input logic pred,
                              input logic [AW-1:0] tgt, input logic [AW-1:0] ft,
                              input logic [CRW-1:0] cnt);
    b_valid = 1; b_resolved = 1; b_taken = taken; b_pred = pred;
    b_target = tgt; b_fallthrough = ft; in_count = cnt;
  endtask

  initial begin
    reset = 1;
    idle_a(); b_target = '0; b_fallthrough = '0; in_count = '0; redirect_ready = 0;
    b_valid1 = 0; b_resolved1 = 0; b_taken1 = 0; b_pred1 = 0;
    b_target1 = '0; b_fallthrough1 = '0; in_count1 = '0; redirect_ready1 = 0;
    step(); step();
    chk("rst_flush", flush, 0);
    chk("rst_stall", issue_stall, 0);
    chk("rst_rv", redirect_valid, 0);
    chk("rst_dv", discard_valid, 0);
    chk("rst_pc", redirect_pc, 0);
    chk("rst_cnt", mispredict_cnt, 0);
    reset = 0;
    step();

    // correct prediction: one-cycle retire, no stall
    drive_branch(1, 1, 14'h200, 14'h011, 4'd2);
    #1 chk("ok_ready", b_ready, 1);
    step();
    idle_a();
    #1 chk("ok_ready_after", b_ready, 0);
    chk("ok_flush", flush, 0);
    chk("ok_stall", issue_stall, 0);
    chk("ok_cnt", mispredict_cnt, 0);

    // taken mispredict to 0x120 with 3 IN ops
    drive_branch(1, 0, 14'h120, 14'h055, 4'd3);
    #1 chk("mp_ready", b_ready, 1);
    step();                                   // T+1
    in_count = 4'd9;                          // must not disturb latched value
    #1 chk("mp_f1_flush", flush, 1);
    chk("mp_f1_stall", issue_stall, 1);
    chk("mp_f1_dv", discard_valid, 1);
    chk("mp_f1_din", discard_in, 3);
    chk("mp_f1_rv", redirect_valid, 0);
    chk("mp_f1_bready", b_ready, 0);
    chk("mp_cnt", mispredict_cnt, 1);
    step();                                   // T+2
    chk("mp_f2_flush", flush, 1);
    chk("mp_f2_dv", discard_valid, 0);
    chk("mp_f2_din", discard_in, 3);
    idle_a();
    step();                                   // T+3
    chk("mp_r_flush", flush, 0);
    chk("mp_r_rv", redirect_valid, 1);
    chk("mp_r_pc", redirect_pc, 14'h120);
    chk("mp_r_stall", issue_stall, 1);
    redirect_ready = 1;
    step();
    redirect_ready = 0;
    chk("mp_idle_rv", redirect_valid, 0);
    chk("mp_idle_stall", issue_stall, 0);

    // not-taken mispredict, fetch stalls the redirect for 5 cycles
    drive_branch(0, 1, 14'h3AA, 14'h101, 4'd7);
    step(); idle_a();
    chk("nt_dv", discard_valid, 1);
    chk("nt_din", discard_in, 7);
    step(); step();
    for (int i = 0; i < 5; i++) begin
      chk("nt_hold_rv", redirect_valid, 1);
      chk("nt_hold_pc", redirect_pc, 14'h101);
      chk("nt_hold_stall", issue_stall, 1);
      if (i < 4) step();
    end
    redirect_ready = 1;
    step();
    redirect_ready = 0;
    chk("nt_idle_rv", redirect_valid, 0);
    chk("nt_idle_stall", issue_stall, 0);
    chk("nt_cnt", mispredict_cnt, 2);

    // head branch waiting on resolution
    b_valid = 1; b_resolved = 0; b_taken = 1; b_pred = 1;
    for (int i = 0; i < 4; i++) begin
      #1 chk("wait_bready", b_ready, 0);
      step();
    end
    b_resolved = 1;
    #1 chk("wait_resolved_bready", b_ready, 1);
    step(); idle_a();
    chk("wait_flush", flush, 0);
    chk("wait_cnt", mispredict_cnt, 2);
    // resolved without valid is ignored
    b_resolved = 1;
    #1 chk("resolved_only_bready", b_ready, 0);
    idle_a();

    // reset during the second flush cycle aborts the redirect
    drive_branch(1, 0, 14'h2F0, 14'h0AB, 4'd5);
    step(); idle_a();
    chk("ra_f1_flush", flush, 1);
    step();
    chk("ra_f2_flush", flush, 1);
    reset = 1;
    step();
    reset = 0;
    chk("ra_flush", flush, 0);
    chk("ra_rv", redirect_valid, 0);
    chk("ra_stall", issue_stall, 0);
    chk("ra_cnt", mispredict_cnt, 0);
    chk("ra_pc", redirect_pc, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("ra_no_rv", redirect_valid, 0);
    end

    // FLUSH_CYCLES=1: back-to-back mispredicts with branch held valid
    b_valid1 = 1; b_resolved1 = 1;
    for (int i = 0; i < 3; i++) begin
      b_pred1 = i[0]; b_taken1 = ~i[0];
      b_target1 = 14'h100 + 14'(i); b_fallthrough1 = 14'h040 + 14'(i);
      in_count1 = 4'(i + 1);
      #1 chk("b2b_bready", b_ready1, 1);
      step();
      chk("b2b_flush", flush1, 1);
      chk("b2b_dv", discard_valid1, 1);
      chk("b2b_din", discard_in1, 4'(i + 1));
      chk("b2b_cnt", mispredict_cnt1, i + 1);
      step();
      chk("b2b_flush_done", flush1, 0);
      chk("b2b_rv", redirect_valid1, 1);
      chk("b2b_pc", redirect_pc1, i[0] ? 14'h040 + 14'(i) : 14'h100 + 14'(i));
      redirect_ready1 = 1;
      step();
      redirect_ready1 = 0;
      chk("b2b_idle_stall", issue_stall1, 0);
    end
    b_valid1 = 0;
    step();
    chk("b2b_final_cnt", mispredict_cnt1, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "timeout");
  end
endmodule

`default_nettype wire
